// File: rtl/sv32_tlb_mmu_pkg.sv
// Shared types and constants for the Sv32 MMU: PTE bit positions, fault codes,
// TLB entry layout, walker states and the leaf permission check.
package sv32_tlb_mmu_pkg;

  localparam logic MEMREQ_READ  = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;

  localparam logic [1:0] CPU_U = 2'b00;
  localparam logic [1:0] CPU_S = 2'b01;
  localparam logic [1:0] CPU_M = 2'b11;

  localparam int unsigned PTE_V = 0;
  localparam int unsigned PTE_R = 1;
  localparam int unsigned PTE_W = 2;
  localparam int unsigned PTE_X = 3;
  localparam int unsigned PTE_U = 4;
  localparam int unsigned PTE_A = 6;
  localparam int unsigned PTE_D = 7;

  localparam logic [4:0] EXC_FETCH_PF = 5'd12;
  localparam logic [4:0] EXC_LOAD_PF  = 5'd13;
  localparam logic [4:0] EXC_STORE_PF = 5'd15;

  typedef enum logic [1:0] {ACC_FETCH, ACC_LOAD, ACC_STORE} acc_t;

  typedef struct packed {
    logic        valid;
    logic [19:0] vpn;
    logic [21:0] ppn;
    logic [7:0]  flags;
    logic        mega;
  } tlb_entry_t;

  typedef enum logic [2:0] {IDLE, WALK1, WALK0, ACCESS, RESPOND} mmu_state_t;

  function automatic logic leaf_ok(input logic [7:0] f, input acc_t acc,
                                   input logic [1:0] mode, input logic mxr,
                                   input logic sum);
    logic ok;
    ok = 1'b1;
    if (f[PTE_U] && mode == CPU_S && !sum) ok = 1'b0;
    if (!f[PTE_U] && mode == CPU_U) ok = 1'b0;
    case (acc)
      ACC_FETCH: if (!f[PTE_X]) ok = 1'b0;
      ACC_LOAD:  if (!(f[PTE_R] || (mxr && f[PTE_X]))) ok = 1'b0;
      default:   if (!f[PTE_W]) ok = 1'b0;
    endcase
    if (!f[PTE_A]) ok = 1'b0;
    if (acc == ACC_STORE && !f[PTE_D]) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [4:0] exc_code(input acc_t acc);
    case (acc)
      ACC_FETCH: return EXC_FETCH_PF;
      ACC_LOAD:  return EXC_LOAD_PF;
      default:   return EXC_STORE_PF;
    endcase
  endfunction

endpackage

// File: rtl/sv32_tlb_mmu_if.sv
// Physical memory bus between the MMU (master) and the memory system (slave).
interface sv32_tlb_mmu_if;
  logic        req_valid;
  logic        req_mode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic [31:0] resp_data;

  modport master (output req_valid, req_mode, req_addr, req_wdata, req_wstrb,
                  input  resp_valid, resp_data);
  modport slave  (input  req_valid, req_mode, req_addr, req_wdata, req_wstrb,
                  output resp_valid, resp_data);
endinterface

// File: rtl/sv32_tlb_mmu_tlb.sv
// Fully-associative TLB: combinational lookup, fill into the lowest free slot or
// round-robin victim, and a whole-array flush that overrides a same-edge fill.
module mmu_tlb
  import sv32_tlb_mmu_pkg::*;
#(
  parameter int unsigned TLB_ENTRIES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] lookup_vpn,
  output logic        hit,
  output tlb_entry_t  hit_entry,
  input  logic        fill_en,
  input  tlb_entry_t  fill_entry,
  input  logic        flush
);
  localparam int unsigned IW = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;

  tlb_entry_t ent_q [TLB_ENTRIES];
  tlb_entry_t ent_d [TLB_ENTRIES];
  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] free_idx;
  logic          have_free;

  // Only one entry can match since fills happen on misses; lowest index wins regardless.
  always_comb begin
    hit       = 1'b0;
    hit_entry = '0;
    for (int unsigned i = 0; i < TLB_ENTRIES; i++) begin
      if (!hit && ent_q[i].valid &&
          (ent_q[i].mega ? (ent_q[i].vpn[19:10] == lookup_vpn[19:10])
                         : (ent_q[i].vpn == lookup_vpn))) begin
        hit       = 1'b1;
        hit_entry = ent_q[i];
      end
    end
  end

  always_comb begin
    ent_d     = ent_q;
    rr_d      = rr_q;
    have_free = 1'b0;
    free_idx  = '0;
    for (int unsigned i = 0; i < TLB_ENTRIES; i++) begin
      if (!have_free && !ent_q[i].valid) begin
        have_free = 1'b1;
        free_idx  = IW'(i);
      end
    end
    if (flush) begin
      for (int unsigned i = 0; i < TLB_ENTRIES; i++) ent_d[i].valid = 1'b0;
    end else if (fill_en) begin
      if (have_free) begin
        ent_d[free_idx] = fill_entry;
      end else begin
        ent_d[rr_q] = fill_entry;
        rr_d        = (rr_q == IW'(TLB_ENTRIES - 1)) ? '0 : rr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q <= '{default: '0};
      rr_q  <= '0;
    end else begin
      ent_q <= ent_d;
      rr_q  <= rr_d;
    end
  end

endmodule

// File: rtl/sv32_tlb_mmu.sv
// Sv32 MMU between the core fetch/mem ports and the physical bus: TLB hits issue
// on the accept edge, misses run a two-level walk that fills the TLB.
module sv32_tlb_mmu
  import sv32_tlb_mmu_pkg::*;
#(
  parameter int unsigned TLB_ENTRIES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] satp,
  input  logic [1:0]  cpu_mode,
  input  logic        mxr,
  input  logic        sum,
  input  logic        tlb_flush,
  input  logic        freq_valid,
  input  logic        freq_mode,
  input  logic [31:0] freq_addr,
  input  logic [31:0] freq_wdata,
  input  logic [3:0]  freq_wstrb,
  output logic        fresp_valid,
  output logic [31:0] fresp_data,
  input  logic        mreq_valid,
  input  logic        mreq_mode,
  input  logic [31:0] mreq_addr,
  input  logic [31:0] mreq_wdata,
  input  logic [3:0]  mreq_wstrb,
  output logic        mresp_valid,
  output logic [31:0] mresp_data,
  output logic        page_fault,
  output logic [4:0]  exception_vec,
  sv32_tlb_mmu_if.master bus
);
  mmu_state_t  state_q, state_d;
  logic [31:0] vaddr_q, vaddr_d, wdata_q, wdata_d;
  logic        mode_q, mode_d;
  logic [3:0]  wstrb_q, wstrb_d;
  acc_t        acc_q, acc_d;
  logic        drop_fill_q, drop_fill_d;
  logic        fresp_valid_q, fresp_valid_d, mresp_valid_q, mresp_valid_d;
  logic [31:0] fresp_data_q, fresp_data_d, mresp_data_q, mresp_data_d;
  logic        page_fault_q, page_fault_d;
  logic [4:0]  exc_q, exc_d;
  logic        req_valid_q, req_valid_d, req_mode_q, req_mode_d;
  logic [31:0] req_addr_q, req_addr_d, req_wdata_q, req_wdata_d;
  logic [3:0]  req_wstrb_q, req_wstrb_d;

  logic        accept, translate, go_access, fault, fill_en, tlb_hit;
  logic [31:0] cur_vaddr, cur_wdata, acc_addr, pte;
  logic        cur_mode;
  logic [3:0]  cur_wstrb;
  acc_t        cur_acc;
  tlb_entry_t  tlb_e, fill_entry;
  logic        unused_bits;

  assign pte       = bus.resp_data;
  assign translate = satp[31] && (cpu_mode != CPU_M);
  assign accept    = (state_q == IDLE) && (freq_valid || mreq_valid);

  // In IDLE the request ports are used directly so hit/bypass can issue on the accept edge.
  always_comb begin
    if (state_q == IDLE) begin
      cur_vaddr = freq_valid ? freq_addr  : mreq_addr;
      cur_mode  = freq_valid ? freq_mode  : mreq_mode;
      cur_wdata = freq_valid ? freq_wdata : mreq_wdata;
      cur_wstrb = freq_valid ? freq_wstrb : mreq_wstrb;
      cur_acc   = freq_valid ? ACC_FETCH :
                  (mreq_mode == MEMREQ_WRITE ? ACC_STORE : ACC_LOAD);
    end else begin
      cur_vaddr = vaddr_q;
      cur_mode  = mode_q;
      cur_wdata = wdata_q;
      cur_wstrb = wstrb_q;
      cur_acc   = acc_q;
    end
  end

  mmu_tlb #(.TLB_ENTRIES(TLB_ENTRIES)) u_tlb (
    .clk       (clk),
    .rst       (rst),
    .lookup_vpn(cur_vaddr[31:12]),
    .hit       (tlb_hit),
    .hit_entry (tlb_e),
    .fill_en   (fill_en),
    .fill_entry(fill_entry),
    .flush     (tlb_flush)
  );

  always_comb begin
    state_d       = state_q;
    vaddr_d       = vaddr_q;
    mode_d        = mode_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    acc_d         = acc_q;
    drop_fill_d   = drop_fill_q | tlb_flush;
    fresp_valid_d = 1'b0;
    mresp_valid_d = 1'b0;
    fresp_data_d  = fresp_data_q;
    mresp_data_d  = mresp_data_q;
    page_fault_d  = page_fault_q;
    exc_d         = exc_q;
    req_valid_d   = 1'b0;
    req_mode_d    = req_mode_q;
    req_addr_d    = req_addr_q;
    req_wdata_d   = req_wdata_q;
    req_wstrb_d   = req_wstrb_q;
    go_access     = 1'b0;
    fault         = 1'b0;
    acc_addr      = '0;
    fill_en       = 1'b0;
    fill_entry    = '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          vaddr_d      = cur_vaddr;
          mode_d       = cur_mode;
          wdata_d      = cur_wdata;
          wstrb_d      = cur_wstrb;
          acc_d        = cur_acc;
          drop_fill_d  = 1'b0;
          page_fault_d = 1'b0;
          exc_d        = '0;
          if (!translate) begin
            go_access = 1'b1;
            acc_addr  = cur_vaddr;
          end else if (tlb_hit) begin
            if (leaf_ok(tlb_e.flags, cur_acc, cpu_mode, mxr, sum)) begin
              go_access = 1'b1;
              acc_addr  = {tlb_e.ppn[19:10],
                           tlb_e.mega ? cur_vaddr[21:12] : tlb_e.ppn[9:0],
                           cur_vaddr[11:0]};
            end else begin
              fault = 1'b1;
            end
          end else begin
            req_valid_d = 1'b1;
            req_mode_d  = MEMREQ_READ;
            req_addr_d  = {satp[19:0], 12'b0} + {20'b0, cur_vaddr[31:22], 2'b0};
            state_d     = WALK1;
          end
        end
      end
      WALK1, WALK0: begin
        if (bus.resp_valid) begin
          if (!pte[PTE_V] || (!pte[PTE_R] && pte[PTE_W])) begin
            fault = 1'b1;
          end else if (pte[PTE_R] || pte[PTE_X]) begin
            if (state_q == WALK1 && pte[19:10] != '0) begin
              fault = 1'b1;
            end else if (!leaf_ok(pte[7:0], acc_q, cpu_mode, mxr, sum)) begin
              fault = 1'b1;
            end else begin
              go_access  = 1'b1;
              acc_addr   = {pte[29:20],
                            (state_q == WALK1) ? vaddr_q[21:12] : pte[19:10],
                            vaddr_q[11:0]};
              fill_en    = !drop_fill_q && !tlb_flush;
              fill_entry = '{valid: 1'b1, vpn: vaddr_q[31:12], ppn: pte[31:10],
                             flags: pte[7:0], mega: (state_q == WALK1)};
            end
          end else if (state_q == WALK1) begin
            req_valid_d = 1'b1;
            req_mode_d  = MEMREQ_READ;
            req_addr_d  = {pte[29:10], 12'b0} + {20'b0, vaddr_q[21:12], 2'b0};
            state_d     = WALK0;
          end else begin
            fault = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (bus.resp_valid) begin
          if (acc_q == ACC_FETCH) begin
            fresp_valid_d = 1'b1;
            fresp_data_d  = bus.resp_data;
          end else begin
            mresp_valid_d = 1'b1;
            mresp_data_d  = bus.resp_data;
          end
          state_d = RESPOND;
        end
      end
      default: state_d = IDLE;
    endcase

    if (go_access) begin
      req_valid_d = 1'b1;
      req_mode_d  = cur_mode;
      req_addr_d  = acc_addr;
      req_wdata_d = cur_wdata;
      req_wstrb_d = cur_wstrb;
      state_d     = ACCESS;
    end
    if (fault) begin
      page_fault_d = 1'b1;
      exc_d        = exc_code(cur_acc);
      if (cur_acc == ACC_FETCH) begin
        fresp_valid_d = 1'b1;
        fresp_data_d  = '0;
      end else begin
        mresp_valid_d = 1'b1;
        mresp_data_d  = '0;
      end
      state_d = RESPOND;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      vaddr_q       <= '0;
      mode_q        <= 1'b0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      acc_q         <= ACC_FETCH;
      drop_fill_q   <= 1'b0;
      fresp_valid_q <= 1'b0;
      mresp_valid_q <= 1'b0;
      fresp_data_q  <= '0;
      mresp_data_q  <= '0;
      page_fault_q  <= 1'b0;
      exc_q         <= '0;
      req_valid_q   <= 1'b0;
      req_mode_q    <= 1'b0;
      req_addr_q    <= '0;
      req_wdata_q   <= '0;
      req_wstrb_q   <= '0;
    end else begin
      state_q       <= state_d;
      vaddr_q       <= vaddr_d;
      mode_q        <= mode_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      acc_q         <= acc_d;
      drop_fill_q   <= drop_fill_d;
      fresp_valid_q <= fresp_valid_d;
      mresp_valid_q <= mresp_valid_d;
      fresp_data_q  <= fresp_data_d;
      mresp_data_q  <= mresp_data_d;
      page_fault_q  <= page_fault_d;
      exc_q         <= exc_d;
      req_valid_q   <= req_valid_d;
      req_mode_q    <= req_mode_d;
      req_addr_q    <= req_addr_d;
      req_wdata_q   <= req_wdata_d;
      req_wstrb_q   <= req_wstrb_d;
    end
  end

  assign fresp_valid   = fresp_valid_q;
  assign fresp_data    = fresp_data_q;
  assign mresp_valid   = mresp_valid_q;
  assign mresp_data    = mresp_data_q;
  assign page_fault    = page_fault_q;
  assign exception_vec = exc_q;
  assign bus.req_valid = req_valid_q;
  assign bus.req_mode  = req_mode_q;
  assign bus.req_addr  = req_addr_q;
  assign bus.req_wdata = req_wdata_q;
  assign bus.req_wstrb = req_wstrb_q;

  assign unused_bits = ^{satp[30:20], tlb_e.valid, tlb_e.vpn, tlb_e.ppn[21:20], pte[9:8]};

endmodule

// File: tb/tb_sv32_tlb_mmu.sv
// Directed bench for sv32_tlb_mmu: a one-cycle-latency bus responder backed by a
// sparse memory and a request log; expected values are hand-computed per step.
module tb_sv32_tlb_mmu;
  import sv32_tlb_mmu_pkg::*;

  logic        clk, rst;
  logic [31:0] satp;
  logic [1:0]  cpu_mode;
  logic        mxr, sum, tlb_flush;
  logic        freq_valid, freq_mode, mreq_valid, mreq_mode;
  logic [31:0] freq_addr, freq_wdata, mreq_addr, mreq_wdata;
  logic [3:0]  freq_wstrb, mreq_wstrb;
  logic        fresp_valid, mresp_valid, page_fault;
  logic [31:0] fresp_data, mresp_data;
  logic [4:0]  exception_vec;

  sv32_tlb_mmu_if bus ();

  sv32_tlb_mmu #(.TLB_ENTRIES(4)) dut (
    .clk(clk), .rst(rst), .satp(satp), .cpu_mode(cpu_mode), .mxr(mxr), .sum(sum),
    .tlb_flush(tlb_flush),
    .freq_valid(freq_valid), .freq_mode(freq_mode), .freq_addr(freq_addr),
    .freq_wdata(freq_wdata), .freq_wstrb(freq_wstrb),
    .fresp_valid(fresp_valid), .fresp_data(fresp_data),
    .mreq_valid(mreq_valid), .mreq_mode(mreq_mode), .mreq_addr(mreq_addr),
    .mreq_wdata(mreq_wdata), .mreq_wstrb(mreq_wstrb),
    .mresp_valid(mresp_valid), .mresp_data(mresp_data),
    .page_fault(page_fault), .exception_vec(exception_vec),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] log_addr [$];
  logic [31:0] log_wdata [$];
  logic        log_wr [$];
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  int unsigned r_lat;
  logic [31:0] r_data;
  logic        r_pf;
  logic [4:0]  r_ev;
  int unsigned n0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_5A5A;
  endfunction

  always @(posedge clk) begin
    bus.resp_valid <= 1'b0;
    if (bus.req_valid && !rst) begin
      bus.resp_valid <= 1'b1;
      bus.resp_data  <= mem_rd(bus.req_addr);
      log_addr.push_back(bus.req_addr);
      log_wdata.push_back(bus.req_wdata);
      log_wr.push_back(bus.req_mode);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input bit fetch, input logic mode, input logic [31:0] addr,
                           input logic [31:0] wdata);
    @(posedge clk);
    @(negedge clk);
    if (fetch) begin
      freq_valid = 1'b1; freq_mode = mode; freq_addr = addr;
      freq_wdata = wdata; freq_wstrb = 4'hF;
    end else begin
      mreq_valid = 1'b1; mreq_mode = mode; mreq_addr = addr;
      mreq_wdata = wdata; mreq_wstrb = 4'hF;
    end
  endtask

  task automatic wait_resp(input bit fetch, input int unsigned flush_at);
    bit got;
    got = 1'b0; r_lat = 0; r_data = '0; r_pf = 1'b0; r_ev = '0;
    for (int unsigned n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      tlb_flush = (n == flush_at);
      if (fetch ? fresp_valid : mresp_valid) begin
        got = 1'b1; r_lat = n;
        r_data = fetch ? fresp_data : mresp_data;
        r_pf = page_fault; r_ev = exception_vec;
        break;
      end
    end
    tlb_flush = 1'b0;
    if (fetch) freq_valid = 1'b0;
    else mreq_valid = 1'b0;
    check("resp_seen", 32'(got), 32'd1);
  endtask

  task automatic do_req(input bit fetch, input logic mode, input logic [31:0] addr,
                        input logic [31:0] wdata, input int unsigned flush_at);
    start_req(fetch, mode, addr, wdata);
    wait_resp(fetch, flush_at);
  endtask

  task automatic pulse_flush();
    @(negedge clk); tlb_flush = 1'b1;
    @(negedge clk); tlb_flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; satp = '0; cpu_mode = CPU_S; mxr = 1'b0; sum = 1'b0; tlb_flush = 1'b0;
    freq_valid = 1'b0; freq_mode = MEMREQ_READ; freq_addr = '0; freq_wdata = '0; freq_wstrb = '0;
    mreq_valid = 1'b0; mreq_mode = MEMREQ_READ; mreq_addr = '0; mreq_wdata = '0; mreq_wstrb = '0;
    mem[32'h0000_1004] = 32'h0004_0001;
    mem[32'h0010_0004] = 32'h2000_00CF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", 32'(bus.req_valid), 32'd0);
    check("rst_req_addr", bus.req_addr, 32'd0);
    check("rst_fresp_valid", 32'(fresp_valid), 32'd0);
    check("rst_mresp_valid", 32'(mresp_valid), 32'd0);
    check("rst_page_fault", 32'(page_fault), 32'd0);
    check("rst_exc", 32'(exception_vec), 32'd0);
    rst = 1'b0;

    // translation off
    n0 = log_addr.size();
    do_req(1'b1, MEMREQ_READ, 32'h0000_0100, 32'h0, 0);
    check("bypass_fetch_lat", r_lat, 32'd3);
    check("bypass_fetch_data", r_data, 32'h0000_0100 ^ 32'h5A5A_5A5A);
    check("bypass_fetch_pf", 32'(r_pf), 32'd0);
    check("bypass_fetch_nreq", log_addr.size() - n0, 32'd1);
    check("bypass_fetch_addr", log_addr[$], 32'h0000_0100);
    do_req(1'b0, MEMREQ_WRITE, 32'h0000_0200, 32'hDEAD_BEEF, 0);
    check("bypass_store_lat", r_lat, 32'd3);
    check("bypass_store_addr", log_addr[$], 32'h0000_0200);
    check("bypass_store_mode", 32'(log_wr[$]), 32'd1);
    check("bypass_store_wdata", log_wdata[$], 32'hDEAD_BEEF);

    // two-level walk, then TLB hit
    satp = 32'h8000_0001;
    n0 = log_addr.size();
    do_req(1'b0, MEMREQ_READ, 32'h0040_1234, 32'h0, 0);
    check("walk2_lat", r_lat, 32'd7);
    check("walk2_pf", 32'(r_pf), 32'd0);
    check("walk2_nreq", log_addr.size() - n0, 32'd3);
    check("walk2_l1_addr", log_addr[n0], 32'h0000_1004);
    check("walk2_l0_addr", log_addr[n0+1], 32'h0010_0004);
    check("walk2_paddr", log_addr[n0+2], 32'h8000_0234);
    check("walk2_data", r_data, 32'h8000_0234 ^ 32'h5A5A_5A5A);
    n0 = log_addr.size();
    do_req(1'b0, MEMREQ_READ, 32'h0040_1234, 32'h0, 0);
    check("hit_lat", r_lat, 32'd3);
    check("hit_nreq", log_addr.size() - n0, 32'd1);
    check("hit_paddr", log_addr[$], 32'h8000_0234);

    cpu_mode = CPU_M;
    do_req(1'b0, MEMREQ_READ, 32'h0040_1234, 32'h0, 0);
    check("mmode_lat", r_lat, 32'd3);
    check("mmode_addr", log_addr[$], 32'h0040_1234);
    cpu_mode = CPU_S;

    // megapages
    pulse_flush();
    mem[32'h0000_1004] = 32'h2000_00CF;
    do_req(1'b0, MEMREQ_READ, 32'h0041_2345, 32'h0, 0);
    check("mega_lat", r_lat, 32'd5);
    check("mega_paddr", log_addr[$], 32'h8001_2345);
    check("mega_pf", 32'(r_pf), 32'd0);
    mem[32'h0000_1008] = 32'h2000_04CF;
    n0 = log_addr.size();
    do_req(1'b0, MEMREQ_READ, 32'h0081_2345, 32'h0, 0);
    check("misalign_lat", r_lat, 32'd3);
    check("misalign_pf", 32'(r_pf), 32'd1);
    check("misalign_exc", 32'(r_ev), 32'd13);
    check("misalign_data", r_data, 32'd0);
    check("misalign_nreq", log_addr.size() - n0, 32'd1);

    // permission faults
    mem[32'h0000_100C] = 32'h2000_004F;
    do_req(1'b0, MEMREQ_READ, 32'h00C0_0010, 32'h0, 0);
    check("clean_load_lat", r_lat, 32'd5);
    check("clean_load_paddr", log_addr[$], 32'h8000_0010);
    n0 = log_addr.size();
    do_req(1'b0, MEMREQ_WRITE, 32'h00C0_0010, 32'h1234_5678, 0);
    check("store_d0_lat", r_lat, 32'd1);
    check("store_d0_pf", 32'(r_pf), 32'd1);
    check("store_d0_exc", 32'(r_ev), 32'd15);
    check("store_d0_nreq", log_addr.size() - n0, 32'd0);
    mem[32'h0000_1010] = 32'h2000_00C7;
    do_req(1'b1, MEMREQ_READ, 32'h0100_0000, 32'h0, 0);
    check("fetch_nx_lat", r_lat, 32'd3);
    check("fetch_nx_pf", 32'(r_pf), 32'd1);
    check("fetch_nx_exc", 32'(r_ev), 32'd12);

    // replacement: five megapages into four entries
    pulse_flush();
    for (int unsigned k = 5; k <= 9; k++) begin
      mem[32'h0000_1000 + 4*k] = ((32'h200 + k) << 20) | 32'hCF;
      do_req(1'b0, MEMREQ_READ, (k << 22) | 32'h88, 32'h0, 0);
      check("fill_lat", r_lat, 32'd5);
      check("fill_paddr", log_addr[$], 32'h8000_0000 | (k << 22) | 32'h88);
    end
    do_req(1'b0, MEMREQ_READ, (32'd6 << 22) | 32'h88, 32'h0, 0);
    check("survivor_hit_lat", r_lat, 32'd3);
    do_req(1'b0, MEMREQ_READ, (32'd5 << 22) | 32'h88, 32'h0, 0);
    check("evicted_lat", r_lat, 32'd5);
    pulse_flush();
    do_req(1'b0, MEMREQ_READ, (32'd7 << 22) | 32'h88, 32'h0, 0);
    check("post_flush_lat", r_lat, 32'd5);

    // flush while in WALK0 suppresses the fill
    mem[32'h0000_1004] = 32'h0004_0001;
    do_req(1'b0, MEMREQ_READ, 32'h0040_1234, 32'h0, 3);
    check("flush_walk0_lat", r_lat, 32'd7);
    check("flush_walk0_paddr", log_addr[$], 32'h8000_0234);
    do_req(1'b0, MEMREQ_READ, 32'h0040_1234, 32'h0, 0);
    check("no_fill_lat", r_lat, 32'd7);
    do_req(1'b0, MEMREQ_READ, 32'h0040_1234, 32'h0, 0);
    check("refill_hit_lat", r_lat, 32'd3);

    // simultaneous requests: fetch first
    satp = '0;
    start_req(1'b1, MEMREQ_READ, 32'h0000_0300, 32'h0);
    mreq_valid = 1'b1; mreq_mode = MEMREQ_READ; mreq_addr = 32'h0000_0400;
    mreq_wdata = '0; mreq_wstrb = 4'hF;
    wait_resp(1'b1, 0);
    check("both_fetch_lat", r_lat, 32'd3);
    check("both_fetch_addr", log_addr[$], 32'h0000_0300);
    wait_resp(1'b0, 0);
    check("both_mem_lat", r_lat, 32'd4);
    check("both_mem_addr", log_addr[$], 32'h0000_0400);

    // reset during WALK1
    satp = 32'h8000_0001;
    start_req(1'b0, MEMREQ_READ, 32'h0240_0000, 32'h0);
    @(posedge clk);
    #1;
    check("walk1_req_valid", 32'(bus.req_valid), 32'd1);
    check("walk1_req_addr", bus.req_addr, 32'h0000_1024);
    rst = 1'b1;
    #1;
    check("midrst_req_valid", 32'(bus.req_valid), 32'd0);
    check("midrst_req_addr", bus.req_addr, 32'd0);
    check("midrst_mresp_valid", 32'(mresp_valid), 32'd0);
    check("midrst_page_fault", 32'(page_fault), 32'd0);
    check("midrst_exc", 32'(exception_vec), 32'd0);
    mreq_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_req(1'b0, MEMREQ_READ, 32'h0040_1234, 32'h0, 0);
    check("post_rst_walk_lat", r_lat, 32'd7);
    check("post_rst_paddr", log_addr[$], 32'h8000_0234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
